// File: rtl/adaptation_pkg.sv
// Shared state codes, width helpers, clamp and parameter-legality checks for the
// adaptive green scheduler.
package adaptation_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] GREEN   = 2'd3;

  function automatic int road_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sum_w(input int cnt_w, input int n);
    return cnt_w + road_w(n);
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic bit params_ok(input int n, input int tg_w, input int tmin, input int tmax);
    return (n >= 2) && ((n & (n - 1)) == 0) && (tmin >= 1) && (tmax >= tmin) &&
           (tmax <= (1 << tg_w) - 1);
  endfunction

endpackage

// File: rtl/green_timer.sv
// Green-phase countdown: load has priority, one decrement per tick, one-cycle done pulse
// on the 1->0 transition. Never stalls; ticks at zero are ignored.
module green_timer #(
  parameter int TG_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [TG_W-1:0] load_val,
  input  logic            tick,
  output logic [TG_W-1:0] remaining,
  output logic            done
);

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        remaining <= load_val;
      end else if (tick && remaining != '0) begin
        remaining <= remaining - TG_W'(1);
        done      <= (remaining == TG_W'(1));
      end
    end
  end

endmodule

// File: rtl/adaptive_green_scheduler.sv
// Adapts one road's green time from its count vs the junction average, then runs it down.
// Result NUM_ROADS+1 edges after start; start is ignored unless IDLE (no queueing).
module adaptive_green_scheduler
  import adaptation_pkg::*;
#(
  parameter int NUM_ROADS  = 4,
  parameter int CNT_W      = 8,
  parameter int TG_W       = 8,
  parameter int GAIN_SHIFT = 1,
  parameter int TG_MIN     = 5,
  parameter int TG_MAX     = 60
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [road_w(NUM_ROADS)-1:0] road_sel,
  input  logic                      tick_en,
  input  logic [NUM_ROADS*CNT_W-1:0] count,
  input  logic [NUM_ROADS*TG_W-1:0]  tg_init,
  output logic [NUM_ROADS*TG_W-1:0]  tg_out,
  output logic                      busy,
  output logic [road_w(NUM_ROADS)-1:0] active_road,
  output logic [TG_W-1:0]           remaining,
  output logic                      phase_done
);

  localparam int ROAD_W = road_w(NUM_ROADS);
  localparam int SUM_W  = sum_w(CNT_W, NUM_ROADS);

  if (!params_ok(NUM_ROADS, TG_W, TG_MIN, TG_MAX)) begin : g_bad_params
    $fatal(1, "adaptive_green_scheduler: illegal NUM_ROADS/TG_MIN/TG_MAX");
  end

  logic [1:0]        state;
  logic [CNT_W-1:0]  count_a [NUM_ROADS];
  logic [TG_W-1:0]   tg_init_a [NUM_ROADS];
  logic [CNT_W-1:0]  snap [NUM_ROADS];
  logic [TG_W-1:0]   tbl [NUM_ROADS];
  logic [SUM_W-1:0]  sum;
  logic [ROAD_W-1:0] idx;
  logic [CNT_W-1:0]  avg;
  logic signed [CNT_W:0] diff;
  logic signed [CNT_W:0] adj;
  logic [TG_W-1:0]   tg_new;

  for (genvar r = 0; r < NUM_ROADS; r++) begin : g_pack
    assign count_a[r]                = count[r*CNT_W +: CNT_W];
    assign tg_init_a[r]              = tg_init[r*TG_W +: TG_W];
    assign tg_out[r*TG_W +: TG_W]    = tbl[r];
  end

  // Base is always tg_init, so repeated phases never compound the adjustment.
  always_comb begin
    avg    = CNT_W'(sum >> ROAD_W);
    diff   = $signed({1'b0, snap[active_road]}) - $signed({1'b0, avg});
    adj    = diff >>> GAIN_SHIFT;
    tg_new = TG_W'(clamp(int'(tg_init_a[active_road]) + int'(adj), TG_MIN, TG_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      active_road <= '0;
      sum         <= '0;
      idx         <= '0;
      for (int r = 0; r < NUM_ROADS; r++) tbl[r] <= tg_init_a[r];
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            active_road <= road_sel;
            for (int r = 0; r < NUM_ROADS; r++) snap[r] <= count_a[r];
            sum   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          sum <= sum + SUM_W'(snap[idx]);
          idx <= idx + ROAD_W'(1);
          if (idx == ROAD_W'(NUM_ROADS - 1)) state <= COMPUTE;
        end
        COMPUTE: begin
          tbl[active_road] <= tg_new;
          state            <= GREEN;
        end
        default: begin
          // Leave GREEN one cycle after the final tick so the done cycle still rejects start.
          if (phase_done) state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  green_timer #(.TG_W(TG_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (state == COMPUTE),
    .load_val  (tg_new),
    .tick      (tick_en && state == GREEN),
    .remaining (remaining),
    .done      (phase_done)
  );

endmodule

// File: tb/tb_adaptive_green_scheduler.sv
// Directed and randomized bench for adaptive_green_scheduler against an arithmetic reference model.
module tb_adaptive_green_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  road_sel = '0;
  logic        tick_en = 1'b0;
  logic [31:0] count = '0;
  logic [31:0] tg_init = '0;
  logic [31:0] tg_out;
  logic        busy;
  logic [1:0]  active_road;
  logic [7:0]  remaining;
  logic        phase_done;

  int checks = 0;
  int errors = 0;
  int cnt [4];
  int tgi [4];
  int exp_tbl [4];
  int rem = 0;

  always #5 clk = ~clk;

  adaptive_green_scheduler #(
    .NUM_ROADS(4), .CNT_W(8), .TG_W(8), .GAIN_SHIFT(1), .TG_MIN(5), .TG_MAX(60)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .road_sel(road_sel), .tick_en(tick_en),
    .count(count), .tg_init(tg_init), .tg_out(tg_out), .busy(busy),
    .active_road(active_road), .remaining(remaining), .phase_done(phase_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_buses();
    for (int r = 0; r < 4; r++) begin
      count[r*8 +: 8]   = 8'(cnt[r]);
      tg_init[r*8 +: 8] = 8'(tgi[r]);
    end
  endtask

  function automatic logic [31:0] pack_tbl();
    logic [31:0] v;
    for (int r = 0; r < 4; r++) v[r*8 +: 8] = 8'(exp_tbl[r]);
    return v;
  endfunction

  // Average of all counts, half the signed deviation rounded toward -inf, clamped to [5,60].
  function automatic int model_tg(input int r);
    int s, avg, d, a, t;
    s = 0;
    for (int i = 0; i < 4; i++) s += cnt[i];
    avg = s / 4;
    d = cnt[r] - avg;
    a = (d >= 0) ? d / 2 : -((-d + 1) / 2);
    t = tgi[r] + a;
    if (t < 5) t = 5;
    if (t > 60) t = 60;
    return t;
  endfunction

  task automatic kick(input int road, input bit disturb);
    int e;
    e = model_tg(road);
    road_sel = 2'(road);
    start = 1'b1;
    tick_en = 1'($urandom_range(0, 1));
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("active_road_latched", active_road, road);
    if (disturb) begin
      cnt = '{30, 34, 25, 15};
      drive_buses();
    end
    for (int i = 0; i < 5; i++) begin
      check("remaining_before_load", remaining, 0);
      check("tg_out_before_compute", tg_out, pack_tbl());
      tick_en = 1'($urandom_range(0, 1));
      step();
    end
    exp_tbl[road] = e;
    rem = e;
    check("tg_out_after_compute", tg_out, pack_tbl());
    check("remaining_loaded", remaining, e);
    check("phase_done_low_on_load", phase_done, 0);
  endtask

  task automatic run_green(input int period, input int stop_at, input bit disturb, input int ar);
    int cyc, strobes, loaded;
    bit done, pd_exp;
    cyc = 0; strobes = 0; loaded = rem; done = 1'b0;
    while (!done) begin
      if (stop_at >= 0 && rem == stop_at) return;
      if (cyc >= 2000) begin
        checks++;
        errors++;
        $error("FAIL green_timeout observed_cycles=%0d expected_done_within=2000", cyc);
        return;
      end
      tick_en = ((cyc % period) == 0);
      if (disturb && cyc == 2) begin
        start = 1'b1;
        road_sel = 2'd1;
      end
      pd_exp = 1'b0;
      if (tick_en && rem > 0) begin
        rem--;
        strobes++;
        pd_exp = (rem == 0);
      end
      step();
      cyc++;
      start = 1'b0;
      tick_en = 1'b0;
      check("remaining", remaining, rem);
      check("phase_done", phase_done, pd_exp);
      check("busy_in_green", busy, 1);
      if (pd_exp) done = 1'b1;
    end
    check("strobes_to_done", strobes, loaded);
    road_sel = 2'($urandom_range(0, 3));
    start = disturb;
    step();
    start = 1'b0;
    check("phase_done_single_cycle", phase_done, 0);
    check("busy_after_done", busy, 0);
    check("active_road_held", active_road, ar);
    if (disturb) begin
      step();
      check("done_cycle_start_ignored", busy, 0);
    end
  endtask

  initial begin
    // Reset: table tracks tg_init while reset is held.
    for (int r = 0; r < 4; r++) tgi[r] = $urandom_range(0, 255);
    drive_buses();
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_remaining", remaining, 0);
    check("rst_phase_done", phase_done, 0);
    check("rst_active_road", active_road, 0);
    for (int r = 0; r < 4; r++) exp_tbl[r] = tgi[r];
    check("rst_tg_out", tg_out, pack_tbl());
    for (int r = 0; r < 4; r++) tgi[r] = $urandom_range(0, 255);
    drive_buses();
    step();
    for (int r = 0; r < 4; r++) exp_tbl[r] = tgi[r];
    check("rst_tg_out_tracks", tg_out, pack_tbl());
    reset = 1'b0;
    step();

    // Widening, floor rounding, lower clamp.
    tgi = '{10, 10, 10, 10};
    cnt = '{43, 22, 20, 15};
    drive_buses();
    kick(0, 0);
    check("widen_value", remaining, 19);
    run_green(1, -1, 0, 0);
    kick(2, 0);
    check("floor_value", remaining, 7);
    run_green(2, -1, 0, 2);
    kick(3, 0);
    check("min_clamp_value", remaining, 5);
    run_green(1, -1, 0, 3);

    // Upper clamp.
    cnt = '{255, 0, 0, 0};
    drive_buses();
    kick(0, 0);
    check("max_clamp_value", remaining, 60);
    run_green(1, -1, 0, 0);

    // Snapshot isolation plus ignored starts during GREEN and in the done cycle.
    cnt = '{43, 22, 20, 15};
    drive_buses();
    kick(0, 1);
    check("snapshot_value", remaining, 19);
    run_green(1, -1, 1, 0);

    // Tick gating: one strobe every third cycle.
    cnt = '{43, 22, 20, 15};
    drive_buses();
    kick(2, 0);
    run_green(3, -1, 0, 2);

    // Reset in the middle of GREEN.
    kick(0, 0);
    run_green(1, 12, 0, 0);
    check("pre_reset_remaining", remaining, 12);
    reset = 1'b1;
    tick_en = 1'b1;
    step();
    reset = 1'b0;
    for (int r = 0; r < 4; r++) exp_tbl[r] = tgi[r];
    rem = 0;
    check("midrst_busy", busy, 0);
    check("midrst_remaining", remaining, 0);
    check("midrst_tg_out", tg_out, pack_tbl());
    for (int i = 0; i < 15; i++) begin
      check("midrst_no_phase_done", phase_done, 0);
      step();
    end
    tick_en = 1'b0;
    kick(1, 0);
    run_green(1, -1, 0, 1);

    // Randomized phases.
    for (int n = 0; n < 12; n++) begin
      int road;
      for (int r = 0; r < 4; r++) begin
        cnt[r] = $urandom_range(0, 255);
        tgi[r] = $urandom_range(0, 255);
      end
      drive_buses();
      road = $urandom_range(0, 3);
      kick(road, 0);
      run_green($urandom_range(1, 3), -1, 0, road);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adaptive_green_scheduler.md
Name: adaptive_green_scheduler

Overview:
- Parametrised, clocked successor to the combinational green-time adaptation block.
- For NUM_ROADS approaches, it recomputes the green time of the selected road from that road's vehicle count relative to the junction average, then clamps it.
- It then runs the green phase as a countdown and reports completion.
- Sits between the sensor counters (count inputs) and the signal-phase controller (start/phase_done handshake).

Parameters:
- NUM_ROADS, 4, number of approaches; must be a power of two and at least 2.
- CNT_W, 8, vehicle-count width per road.
- TG_W, 8, green-time width per road, in ticks.
- GAIN_SHIFT, 1, arithmetic right-shift applied to the count deviation.
- TG_MIN, 5, lower clamp on green time; must be at least 1.
- TG_MAX, 60, upper clamp on green time; must be at least TG_MIN and at most 2^TG_W-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request adaptation plus green phase for road_sel; sampled only in IDLE.
- road_sel  in  log2(NUM_ROADS)  road to adapt and serve.
- tick_en  in  1  green-time tick strobe (one per time unit).
- count  in  NUM_ROADS*CNT_W  flattened vehicle counts; road r occupies bits [r*CNT_W +: CNT_W].
- tg_init  in  NUM_ROADS*TG_W  flattened base green times, same packing as count.
- tg_out  out  NUM_ROADS*TG_W  current green-time table.
- busy  out  1  high in every state other than IDLE.
- active_road  out  log2(NUM_ROADS)  road latched at start.
- remaining  out  TG_W  ticks left in the current green phase.
- phase_done  out  1  single-cycle pulse when remaining reaches 0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values, applied every cycle reset is high:
  - state=IDLE; busy=0; phase_done=0; remaining=0; active_road=0.
  - tg_out loads tg_init, so it tracks tg_init while reset is held.
- Reset mid-operation aborts immediately. No phase_done is issued.
- State IDLE:
  - start=1 samples road_sel into active_road and snapshots the whole count bus.
  - Clears sum and index, then moves to ACCUM. busy rises on the next edge.
  - start in any other state is ignored. No queueing.
- State ACCUM:
  - Each cycle, sum += snapshot[idx] and idx++.
  - After NUM_ROADS cycles, moves to COMPUTE.
  - sum width is CNT_W+log2(NUM_ROADS), so it cannot overflow.
  - Later changes on count have no effect; only the snapshot is used.
- State COMPUTE (one cycle):
  - avg = sum >> log2(NUM_ROADS), truncating.
  - diff = snapshot[r] - avg, signed, CNT_W+1 bits.
  - adj = diff >>> GAIN_SHIFT, arithmetic, so it floors toward -inf.
  - tg_new = tg_init[r] + adj, signed, TG_W+2 bits.
  - Clamp tg_new to [TG_MIN, TG_MAX].
  - Write tg_new to tg_out[r]; all other entries hold.
  - Load remaining=tg_new and move to GREEN.
  - The base is always tg_init, not the previous tg_out, so adaptation is non-cumulative.
- Latency: tg_out[r] and remaining update on the (NUM_ROADS+1)th edge after the edge that sampled start.
- State GREEN:
  - Each cycle with tick_en=1 and remaining>0: remaining--.
  - On the tick that takes remaining from 1 to 0: phase_done=1 for exactly one cycle, state returns to IDLE, busy falls.
  - tick_en is ignored outside GREEN.
- A start asserted in the phase_done cycle is ignored, because the state is still GREEN. It must be re-presented in IDLE.
- No zero-length phase is possible, since TG_MIN is at least 1.

Decomposition:
- Package adaptation_pkg holds:
  - the state enum (IDLE, ACCUM, COMPUTE, GREEN);
  - clog2-based width constants (ROAD_W, SUM_W);
  - a clamp function;
  - parameter-legality checks, with elaboration-time assertions for power of two, TG_MIN ≥ 1 and TG_MAX range.
- Sub-module green_timer holds the load/decrement/phase_done countdown. It is instantiated once.

Test Plan:
- Widening: NUM_ROADS=4, GAIN_SHIFT=1, tg_init all 10, count={N:43,E:22,S:20,W:15}, start road 0 -> after 5 edges tg_out[0]=19 (avg 25, adj +9), others 10, remaining=19; 19 ticks later phase_done pulse, busy=0.
- Floor rounding and lower clamp: same counts, start road 2 -> tg_out[2]=7 (diff -5, adj -3); start road 3 -> tg_out[3]=5 (adj -5, equals TG_MIN).
- Upper clamp: count={255,0,0,0}, tg_init 10, road 0 -> avg 63, adj 96, tg_out[0]=60 (TG_MAX).
- Snapshot and ignored start: change count to {30,34,25,15} during ACCUM and pulse start with road_sel=1 during GREEN -> result uses the old snapshot; no second phase; start in the phase_done cycle is ignored.
- Tick gating: tick_en high only every 3rd cycle with tg=7 -> phase_done after exactly 7 strobes (about 21 cycles); remaining holds between strobes.
- Reset mid-GREEN: reset for 1 cycle with remaining=12 -> next edge busy=0, remaining=0, tg_out=tg_init, no phase_done; a fresh start then works normally.
